reg_write_arbiter: RTL and testbench

Shares the register file's single write port (WriteEnable/WriteAddr/WriteData) between two writeback requesters:
- A: primary ALU/load result, never back-pressured.
- B: secondary writeback, e.g. base-register update for pre/post-indexed LDR/STR.

Deferred B writes wait in a small in-order queue. The block flags read-after-write hazards against queued entries so the core can stall. It sits between the writeback stage and the register file.

---
 rtl/reg_write_arbiter.sv | 171 +++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Shares the register file's single write port between a primary (A) and a deferred (B) writeback requester.
// Optional forwarding of queued data instead of hazard stalls: define REGARB_FWD_EN.
module reg_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          A_Valid,
    input  logic [AW-1:0] A_Addr,
    input  logic [DW-1:0] A_Data,
    input  logic          B_Valid,
    input  logic [AW-1:0] B_Addr,
    input  logic [DW-1:0] B_Data,
    output logic          B_Ready,
    input  logic [AW-1:0] ReadAddr1,
    input  logic [AW-1:0] ReadAddr2,
    output logic          Hazard1,
    output logic          Hazard2,
    output logic          Stall,
`ifdef REGARB_FWD_EN
    output logic          FwdValid1,
    output logic [DW-1:0] FwdData1,
    output logic          FwdValid2,
    output logic [DW-1:0] FwdData2,
`endif
    output logic          WriteEnable,
    output logic [AW-1:0] WriteAddr,
    output logic [DW-1:0] WriteData,
    output logic [3:0]    Pending
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PC_ADDR = '1;
    localparam logic [3:0]    DEPTH_L = 4'(DEPTH);

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_live;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [3:0]       r_count;

    logic             w_a_active;
    logic             w_empty;
    logic             w_pop;
    logic             w_b_fire;
    logic             w_bypass;
    logic             w_push;
    logic [DEPTH-1:0] w_kill;
    logic [DEPTH-1:0] w_hit1;
    logic [DEPTH-1:0] w_hit2;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // An A write to the PC never reaches the register file, so it leaves the port free for the queue.
    assign w_a_active = A_Valid & (A_Addr != PC_ADDR);
    assign w_empty    = (r_count == 4'd0);
    assign B_Ready    = (r_count < DEPTH_L) & ~RESET;
    assign w_pop      = ~w_a_active & ~w_empty & ~RESET;
    assign w_b_fire   = B_Valid & B_Ready;
    assign w_bypass   = ~w_a_active & w_empty & w_b_fire;
    assign w_push     = w_b_fire & ~w_bypass;
    assign Pending    = r_count;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign w_kill[gi] = w_a_active & r_valid[gi] & r_live[gi] & (r_addr[gi] == A_Addr);
            assign w_hit1[gi] = r_valid[gi] & r_live[gi] & (r_addr[gi] == ReadAddr1) & (ReadAddr1 != PC_ADDR);
            assign w_hit2[gi] = r_valid[gi] & r_live[gi] & (r_addr[gi] == ReadAddr2) & (ReadAddr2 != PC_ADDR);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_addr[r_tail] <= B_Addr;
            r_data[r_tail] <= B_Data;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_valid <= '0;
            r_live  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Older queued writes to A's register would clobber the newer value; neutralise them.
            r_live <= r_live & ~w_kill;
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= next_ptr(r_head);
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_live[r_tail]  <= (B_Addr != PC_ADDR);
                r_tail          <= next_ptr(r_tail);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        WriteEnable = 1'b0;
        WriteAddr   = '0;
        WriteData   = '0;
        if (RESET) begin
            WriteEnable = 1'b0;
        end else if (w_a_active) begin
            WriteEnable = 1'b1;
            WriteAddr   = A_Addr;
            WriteData   = A_Data;
        end else if (w_pop) begin
            WriteEnable = r_live[r_head];
            WriteAddr   = r_addr[r_head];
            WriteData   = r_data[r_head];
        end else if (w_bypass) begin
            WriteEnable = (B_Addr != PC_ADDR);
            WriteAddr   = B_Addr;
            WriteData   = B_Data;
        end
    end

`ifdef REGARB_FWD_EN
    logic [PW-1:0] w_ord [DEPTH];

    // w_ord[k] is the slot holding the k-th oldest entry; walking it oldest-first leaves the youngest match.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ord
            logic [PW:0] w_sum;
            assign w_sum     = {1'b0, r_head} + (PW + 1)'(gi);
            assign w_ord[gi] = (w_sum >= (PW + 1)'(DEPTH)) ? PW'(w_sum - (PW + 1)'(DEPTH)) : PW'(w_sum);
        end
    endgenerate

    always_comb begin
        FwdValid1 = 1'b0;
        FwdData1  = '0;
        FwdValid2 = 1'b0;
        FwdData2  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_hit1[w_ord[k]]) begin
                FwdValid1 = 1'b1;
                FwdData1  = r_data[w_ord[k]];
            end
            if (w_hit2[w_ord[k]]) begin
                FwdValid2 = 1'b1;
                FwdData2  = r_data[w_ord[k]];
            end
        end
    end

    assign Hazard1 = 1'b0;
    assign Hazard2 = 1'b0;
    assign Stall   = B_Valid & ~B_Ready & ~RESET;
`else
    assign Hazard1 = (|w_hit1) & ~RESET;
    assign Hazard2 = (|w_hit2) & ~RESET;
    assign Stall   = (Hazard1 | Hazard2 | (B_Valid & ~B_Ready)) & ~RESET;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (DEPTH=2); forwarding checks run when REGARB_FWD_EN is defined.
module tb_reg_write_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        A_Valid, B_Valid;
    logic [3:0]  A_Addr, B_Addr, ReadAddr1, ReadAddr2;
    logic [31:0] A_Data, B_Data;
    logic        B_Ready, Hazard1, Hazard2, Stall, WriteEnable;
    logic [3:0]  WriteAddr, Pending;
    logic [31:0] WriteData;
`ifdef REGARB_FWD_EN
    logic        FwdValid1, FwdValid2;
    logic [31:0] FwdData1, FwdData2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    reg_write_arbiter #(.DEPTH(2), .DW(32), .AW(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .A_Valid(A_Valid), .A_Addr(A_Addr), .A_Data(A_Data),
        .B_Valid(B_Valid), .B_Addr(B_Addr), .B_Data(B_Data), .B_Ready(B_Ready),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
        .Hazard1(Hazard1), .Hazard2(Hazard2), .Stall(Stall),
`ifdef REGARB_FWD_EN
        .FwdValid1(FwdValid1), .FwdData1(FwdData1), .FwdValid2(FwdValid2), .FwdData2(FwdData2),
`endif
        .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData), .Pending(Pending)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        A_Valid = 1'b0; A_Addr = 4'd0; A_Data = 32'd0;
        B_Valid = 1'b0; B_Addr = 4'd0; B_Data = 32'd0;
    endtask

    task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [3:0] ba, input logic [31:0] bd);
        A_Valid = av; A_Addr = aa; A_Data = ad;
        B_Valid = bv; B_Addr = ba; B_Data = bd;
        #3;
        $display("t=%0t A=%b/%0h/%0h B=%b/%0h/%0h -> WE=%b WA=%0h WD=%0h Rdy=%b Pend=%0d Hz=%b%b Stall=%b",
                 $time, av, aa, ad, bv, ba, bd, WriteEnable, WriteAddr, WriteData, B_Ready, Pending, Hazard1, Hazard2, Stall);
    endtask

    task automatic test_reset();
        RESET = 1'b1; idle(); ReadAddr1 = 4'd0; ReadAddr2 = 4'd0;
        B_Valid = 1'b1; B_Addr = 4'd3;
        #2;
        n_checks++; if (Pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending got=%0d exp=0", Pending); end
        n_checks++; if (WriteEnable !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", WriteEnable); end
        n_checks++; if (B_Ready !== 1'b0) begin n_fail++; $display("FAIL reset_bready got=%b exp=0", B_Ready); end
        n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", Stall); end
        n_checks++; if (Hazard1 !== 1'b0) begin n_fail++; $display("FAIL reset_hazard1 got=%b exp=0", Hazard1); end
        idle();
        #1 RESET = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        ReadAddr1 = 4'd3;
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h55);
        n_checks++; if (WriteEnable !== 1'b1) begin n_fail++; $display("FAIL bypass_we got=%b exp=1", WriteEnable); end
        n_checks++; if (WriteAddr !== 4'd3) begin n_fail++; $display("FAIL bypass_waddr got=%0h exp=3", WriteAddr); end
        n_checks++; if (WriteData !== 32'h55) begin n_fail++; $display("FAIL bypass_wdata got=%0h exp=55", WriteData); end
        n_checks++; if (B_Ready !== 1'b1) begin n_fail++; $display("FAIL bypass_bready got=%b exp=1", B_Ready); end
        n_checks++; if (Hazard1 !== 1'b0) begin n_fail++; $display("FAIL bypass_hazard got=%b exp=0", Hazard1); end
        tick(); idle(); #3;
        n_checks++; if (Pending !== 4'd0) begin n_fail++; $display("FAIL bypass_pending got=%0d exp=0", Pending); end
        ReadAddr1 = 4'd0;
        tick();
    endtask

    task automatic test_conflict();
        ReadAddr1 = 4'd5; ReadAddr2 = 4'd5;
        drive(1'b1, 4'd2, 32'h11, 1'b1, 4'd5, 32'h22);
        n_checks++; if (WriteAddr !== 4'd2 || WriteData !== 32'h11 || WriteEnable !== 1'b1) begin n_fail++; $display("FAIL conflict_a_write got=%b/%0h/%0h exp=1/2/11", WriteEnable, WriteAddr, WriteData); end
        n_checks++; if (B_Ready !== 1'b1) begin n_fail++; $display("FAIL conflict_bready got=%b exp=1", B_Ready); end
        n_checks++; if (Hazard1 !== 1'b0) begin n_fail++; $display("FAIL conflict_hazard_c0 got=%b exp=0", Hazard1); end
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        n_checks++; if (Pending !== 4'd1) begin n_fail++; $display("FAIL conflict_pending1 got=%0d exp=1", Pending); end
`ifndef REGARB_FWD_EN
        n_checks++; if (Hazard1 !== 1'b1) begin n_fail++; $display("FAIL conflict_hazard1 got=%b exp=1", Hazard1); end
        n_checks++; if (Hazard2 !== 1'b1) begin n_fail++; $display("FAIL conflict_hazard2 got=%b exp=1", Hazard2); end
        n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL conflict_stall got=%b exp=1", Stall); end
`endif
        n_checks++; if (WriteAddr !== 4'd5 || WriteData !== 32'h22 || WriteEnable !== 1'b1) begin n_fail++; $display("FAIL conflict_pop got=%b/%0h/%0h exp=1/5/22", WriteEnable, WriteAddr, WriteData); end
        tick(); #3;
        n_checks++; if (Pending !== 4'd0) begin n_fail++; $display("FAIL conflict_pending0 got=%0d exp=0", Pending); end
        n_checks++; if (WriteEnable !== 1'b0) begin n_fail++; $display("FAIL conflict_idle_we got=%b exp=0", WriteEnable); end
        ReadAddr1 = 4'd0; ReadAddr2 = 4'd0;
        tick();
    endtask

    task automatic test_full();
        drive(1'b1, 4'd8, 32'h80, 1'b1, 4'd1, 32'h101);
        n_checks++; if (B_Ready !== 1'b1 || WriteAddr !== 4'd8) begin n_fail++; $display("FAIL full_c0 got=rdy%b wa%0h exp=rdy1 wa8", B_Ready, WriteAddr); end
        tick();
        drive(1'b1, 4'd8, 32'h81, 1'b1, 4'd4, 32'h104);
        n_checks++; if (Pending !== 4'd1 || B_Ready !== 1'b1) begin n_fail++; $display("FAIL full_c1 got=pend%0d rdy%b exp=pend1 rdy1", Pending, B_Ready); end
        tick();
        drive(1'b1, 4'd8, 32'h82, 1'b1, 4'd6, 32'h106);
        n_checks++; if (Pending !== 4'd2) begin n_fail++; $display("FAIL full_pending2 got=%0d exp=2", Pending); end
        n_checks++; if (B_Ready !== 1'b0 || Stall !== 1'b1) begin n_fail++; $display("FAIL full_backpressure got=rdy%b stall%b exp=rdy0 stall1", B_Ready, Stall); end
        n_checks++; if (WriteAddr !== 4'd8 || WriteData !== 32'h82) begin n_fail++; $display("FAIL full_a_write got=%0h/%0h exp=8/82", WriteAddr, WriteData); end
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h106);
        n_checks++; if (B_Ready !== 1'b0 || Stall !== 1'b1) begin n_fail++; $display("FAIL full_no_popthrough got=rdy%b stall%b exp=rdy0 stall1", B_Ready, Stall); end
        n_checks++; if (WriteEnable !== 1'b1 || WriteAddr !== 4'd1 || WriteData !== 32'h101) begin n_fail++; $display("FAIL full_pop1 got=%b/%0h/%0h exp=1/1/101", WriteEnable, WriteAddr, WriteData); end
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h106);
        n_checks++; if (Pending !== 4'd1 || B_Ready !== 1'b1) begin n_fail++; $display("FAIL full_accept got=pend%0d rdy%b exp=pend1 rdy1", Pending, B_Ready); end
        n_checks++; if (WriteAddr !== 4'd4 || WriteData !== 32'h104) begin n_fail++; $display("FAIL full_pop2 got=%0h/%0h exp=4/104", WriteAddr, WriteData); end
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        n_checks++; if (Pending !== 4'd1) begin n_fail++; $display("FAIL full_push_pop_pending got=%0d exp=1", Pending); end
        n_checks++; if (WriteEnable !== 1'b1 || WriteAddr !== 4'd6 || WriteData !== 32'h106) begin n_fail++; $display("FAIL full_pop3 got=%b/%0h/%0h exp=1/6/106", WriteEnable, WriteAddr, WriteData); end
        tick(); #3;
        n_checks++; if (Pending !== 4'd0 || WriteEnable !== 1'b0) begin n_fail++; $display("FAIL full_drained got=pend%0d we%b exp=pend0 we0", Pending, WriteEnable); end
        tick();
    endtask

    task automatic test_kill();
        drive(1'b1, 4'd2, 32'h1, 1'b1, 4'd7, 32'hAA);
        tick();
        ReadAddr1 = 4'd7;
        drive(1'b1, 4'd7, 32'hBB, 1'b0, 4'd0, 32'd0);
        n_checks++; if (WriteEnable !== 1'b1 || WriteAddr !== 4'd7 || WriteData !== 32'hBB) begin n_fail++; $display("FAIL kill_a_write got=%b/%0h/%0h exp=1/7/bb", WriteEnable, WriteAddr, WriteData); end
`ifndef REGARB_FWD_EN
        n_checks++; if (Hazard1 !== 1'b1) begin n_fail++; $display("FAIL kill_hazard_before got=%b exp=1", Hazard1); end
`endif
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        n_checks++; if (Pending !== 4'd1) begin n_fail++; $display("FAIL kill_pending_kept got=%0d exp=1", Pending); end
        n_checks++; if (WriteEnable !== 1'b0) begin n_fail++; $display("FAIL kill_pop_we got=%b exp=0", WriteEnable); end
        n_checks++; if (Hazard1 !== 1'b0 || Stall !== 1'b0) begin n_fail++; $display("FAIL kill_hazard_after got=hz%b stall%b exp=hz0 stall0", Hazard1, Stall); end
        tick(); #3;
        n_checks++; if (Pending !== 4'd0) begin n_fail++; $display("FAIL kill_drained got=%0d exp=0", Pending); end
        ReadAddr1 = 4'd0;
        tick();
    endtask

    task automatic test_pc();
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'hF, 32'h1234);
        n_checks++; if (B_Ready !== 1'b1 || WriteEnable !== 1'b0) begin n_fail++; $display("FAIL pc_b_drop got=rdy%b we%b exp=rdy1 we0", B_Ready, WriteEnable); end
        tick(); idle(); #3;
        n_checks++; if (Pending !== 4'd0) begin n_fail++; $display("FAIL pc_b_pending got=%0d exp=0", Pending); end
        tick();
        drive(1'b1, 4'd2, 32'h2, 1'b1, 4'd9, 32'h99);
        tick();
        drive(1'b1, 4'hF, 32'h5, 1'b0, 4'd0, 32'd0);
        n_checks++; if (WriteEnable !== 1'b1 || WriteAddr !== 4'd9 || WriteData !== 32'h99) begin n_fail++; $display("FAIL pc_a_passthru got=%b/%0h/%0h exp=1/9/99", WriteEnable, WriteAddr, WriteData); end
        tick(); idle(); #3;
        n_checks++; if (Pending !== 4'd0) begin n_fail++; $display("FAIL pc_a_pending got=%0d exp=0", Pending); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'd3, 32'h3, 1'b1, 4'd10, 32'hA0);
        tick();
        drive(1'b1, 4'd3, 32'h3, 1'b1, 4'd11, 32'hA1);
        tick();
        idle(); #1;
        n_checks++; if (Pending !== 4'd2 || WriteEnable !== 1'b1 || WriteAddr !== 4'd10) begin n_fail++; $display("FAIL rstmid_before got=pend%0d we%b wa%0h exp=pend2 we1 waa", Pending, WriteEnable, WriteAddr); end
        #1 RESET = 1'b1;
        #1;
        n_checks++; if (Pending !== 4'd0 || WriteEnable !== 1'b0) begin n_fail++; $display("FAIL rstmid_async got=pend%0d we%b exp=pend0 we0", Pending, WriteEnable); end
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        tick(); #3;
        n_checks++; if (WriteEnable !== 1'b0 || Pending !== 4'd0) begin n_fail++; $display("FAIL rstmid_after1 got=we%b pend%0d exp=we0 pend0", WriteEnable, Pending); end
        tick(); #3;
        n_checks++; if (WriteEnable !== 1'b0 || Pending !== 4'd0) begin n_fail++; $display("FAIL rstmid_after2 got=we%b pend%0d exp=we0 pend0", WriteEnable, Pending); end
        tick();
    endtask

`ifdef REGARB_FWD_EN
    task automatic test_fwd();
        ReadAddr2 = 4'd9;
        drive(1'b1, 4'd2, 32'h2, 1'b1, 4'd9, 32'h77);
        tick();
        drive(1'b1, 4'd2, 32'h2, 1'b1, 4'd9, 32'h88);
        n_checks++; if (FwdValid2 !== 1'b1 || FwdData2 !== 32'h77) begin n_fail++; $display("FAIL fwd_single got=%b/%0h exp=1/77", FwdValid2, FwdData2); end
        n_checks++; if (Hazard2 !== 1'b0 || FwdValid1 !== 1'b0) begin n_fail++; $display("FAIL fwd_hazard got=hz%b fv1%b exp=hz0 fv10", Hazard2, FwdValid1); end
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        n_checks++; if (FwdValid2 !== 1'b1 || FwdData2 !== 32'h88) begin n_fail++; $display("FAIL fwd_youngest got=%b/%0h exp=1/88", FwdValid2, FwdData2); end
        n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall got=%b exp=0", Stall); end
        tick(); tick(); #3;
        n_checks++; if (FwdValid2 !== 1'b0 || Pending !== 4'd0) begin n_fail++; $display("FAIL fwd_drained got=fv%b pend%0d exp=fv0 pend0", FwdValid2, Pending); end
        ReadAddr2 = 4'd0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_bypass();
        test_conflict();
        test_full();
        test_kill();
        test_pc();
        test_reset_mid();
`ifdef REGARB_FWD_EN
        test_fwd();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
